ct_pack: RTL

Ciphertext serializer for ML-KEM-768 encapsulation, directly downstream of the encapsulation sequencer. After the sequencer leaves compressed u[0..2] (D=10) in slots 16-18 and compressed v (D=4) in slot 19 of the kyber_top polynomial bank, ct_pack reads those slots through the bank read port. It packs coefficients LSB-first per ByteEncode and streams the 1088-byte ciphertext c = c1‖c2 out on a valid/ready byte interface.

---
 rtl/kyber_pkg.sv | 35 +++
 rtl/bit_accum.sv | 50 +++++
 rtl/ct_pack.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/kyber_pkg.sv
// kyber_pkg: constants shared by kyber_top, the encapsulation sequencer and ct_pack.
// Holds polynomial-bank slot assignments, ML-KEM-768 compression widths, the
// ciphertext length and the serializer FSM state type.

package kyber_pkg;

   // ML-KEM-768 parameters
   localparam int K      = 3;     // module rank
   localparam int DU     = 10;    // bits per compressed u coefficient
   localparam int DV     = 4;     // bits per compressed v coefficient
   localparam int N_COEF = 256;   // coefficients per polynomial

   // Polynomial-bank slots written by the encapsulation sequencer
   localparam int U_BASE_SLOT = 16;   // u[i] lives in U_BASE_SLOT+i
   localparam int V_SLOT      = 19;

   // Bit-packing accumulator width (7 leftover bits + one 10-bit coefficient fits easily)
   localparam int ACC_W = 24;

   // Ciphertext length in bytes: 256*(K*DU + DV)/8
   function automatic int ct_len(input int k, input int du, input int dv);
      return (N_COEF / 8) * (k * du + dv);
   endfunction

   localparam int CT_BYTES = ct_len(K, DU, DV);   // 1088 for ML-KEM-768

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_LOAD,
      ST_DRAIN,
      ST_DONE
   } ct_state_t;

endpackage

// File: rtl/bit_accum.sv
// bit_accum: LSB-first bit accumulator; appends a variable-width field, emits bytes from the bottom.
// Latency: append/shift take effect at the next clock edge; acc_byte/acc_cnt are register outputs.
// Backpressure: none internally; the owner only shifts when a byte is actually accepted.
// Ports: clr (empty the accumulator), app_en/app_dat/app_w (append app_w LSBs of app_dat),
//        shift_en (drop the low byte), acc_byte (low 8 bits), acc_cnt (valid bit count).

module bit_accum
   import kyber_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        app_en,
   input  logic [11:0] app_dat,
   input  logic [3:0]  app_w,
   input  logic        shift_en,
   output logic [7:0]  acc_byte,
   output logic [4:0]  acc_cnt
);

   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] app_mask;
   logic [ACC_W-1:0] app_bits;

   // Bits of app_dat above app_w are discarded before landing at position acc_cnt.
   always_comb begin
      app_mask = ~({ACC_W{1'b1}} << app_w);
      app_bits = ({{(ACC_W-12){1'b0}}, app_dat} & app_mask) << acc_cnt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc     <= '0;
         acc_cnt <= '0;
      end else if (clr) begin
         acc     <= '0;
         acc_cnt <= '0;
      end else if (app_en) begin
         // Everything at or above acc_cnt is already zero, so OR-in is enough.
         acc     <= acc | app_bits;
         acc_cnt <= acc_cnt + 5'(app_w);
      end else if (shift_en) begin
         acc     <= acc >> 8;
         acc_cnt <= acc_cnt - 5'd8;
      end
   end

   assign acc_byte = acc[7:0];

endmodule

// File: rtl/ct_pack.sv
// ct_pack: serializes compressed u[0..K-1] (DU bits) and v (DV bits) from the bank into c = c1||c2 bytes.
// Latency: rd_en one cycle after start is sampled; 2 cycles per coefficient + 1 per byte with ct_ready high.
// Backpressure: ct_valid/ct_data/ct_last hold while !ct_ready; no further bank reads until the byte drains.
// Ports: start/busy/done (control), rd_en/rd_slot/rd_addr/rd_data (bank port, 1-cycle read latency),
//        ct_data/ct_valid/ct_ready/ct_last (byte stream, ct_last marks the final byte).

module ct_pack #(
   parameter int K           = kyber_pkg::K,
   parameter int DU          = kyber_pkg::DU,
   parameter int DV          = kyber_pkg::DV,
   parameter int U_BASE_SLOT = kyber_pkg::U_BASE_SLOT,
   parameter int V_SLOT      = kyber_pkg::V_SLOT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        rd_en,
   output logic [4:0]  rd_slot,
   output logic [7:0]  rd_addr,
   input  logic [11:0] rd_data,
   output logic [7:0]  ct_data,
   output logic        ct_valid,
   input  logic        ct_ready,
   output logic        ct_last
);

   import kyber_pkg::*;

   localparam logic [10:0] LAST_BYTE = 11'(ct_len(K, DU, DV) - 1);
   localparam logic [7:0]  LAST_N    = 8'(N_COEF - 1);

   ct_state_t   state, state_nxt;
   logic [2:0]  p, p_nxt;            // polynomial index; K selects v, K+1 means all loaded
   logic [7:0]  n, n_nxt;            // coefficient index
   logic [10:0] byte_cnt, byte_nxt;  // bytes handed off so far

   logic        busy_nxt, done_nxt, rd_en_nxt, ct_valid_nxt, ct_last_nxt;
   logic [4:0]  rd_slot_nxt;
   logic [7:0]  rd_addr_nxt;

   logic        acc_clr, acc_app, acc_shift;
   logic [3:0]  coef_w;
   logic [4:0]  acc_cnt;
   logic [4:0]  cnt_loaded;
   logic        last_coef;

   bit_accum u_accum (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (acc_clr),
      .app_en   (acc_app),
      .app_dat  (rd_data),
      .app_w    (coef_w),
      .shift_en (acc_shift),
      .acc_byte (ct_data),
      .acc_cnt  (acc_cnt)
   );

   always_comb begin
      coef_w     = (p < 3'(K)) ? 4'(DU) : 4'(DV);
      cnt_loaded = acc_cnt + 5'(coef_w);
      last_coef  = (p == 3'(K)) && (n == LAST_N);
   end

   always_comb begin
      state_nxt = state;
      p_nxt     = p;
      n_nxt     = n;
      byte_nxt  = byte_cnt;
      acc_clr   = 1'b0;
      acc_app   = 1'b0;
      acc_shift = 1'b0;

      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt = ST_FETCH;
               p_nxt     = '0;
               n_nxt     = '0;
               byte_nxt  = '0;
               acc_clr   = 1'b1;
            end
         end
         ST_FETCH: state_nxt = ST_LOAD;
         ST_LOAD: begin
            acc_app = 1'b1;
            n_nxt   = n + 8'd1;
            if (n == LAST_N) p_nxt = p + 3'd1;
            // Skip DRAIN entirely when no whole byte is ready, so every DRAIN cycle offers a byte.
            if (cnt_loaded >= 5'd8)  state_nxt = ST_DRAIN;
            else if (!last_coef)     state_nxt = ST_FETCH;
            else                     state_nxt = ST_DONE;
         end
         ST_DRAIN: begin
            // ct_valid is high throughout DRAIN, so ct_ready alone marks a handshake.
            if (ct_ready) begin
               acc_shift = 1'b1;
               byte_nxt  = byte_cnt + 11'd1;
               if (acc_cnt >= 5'd16)    state_nxt = ST_DRAIN;
               else if (p <= 3'(K))     state_nxt = ST_FETCH;
               else                     state_nxt = ST_DONE;
            end
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase

      // Outputs are registered from next-state values so nothing reaches a port combinationally.
      busy_nxt     = (state_nxt != ST_IDLE);
      done_nxt     = (state_nxt == ST_DONE);
      rd_en_nxt    = (state_nxt == ST_FETCH);
      ct_valid_nxt = (state_nxt == ST_DRAIN);
      ct_last_nxt  = ct_valid_nxt && (byte_nxt == LAST_BYTE);
      rd_slot_nxt  = rd_slot;
      rd_addr_nxt  = rd_addr;
      if (rd_en_nxt) begin
         rd_slot_nxt = (p_nxt < 3'(K)) ? 5'(U_BASE_SLOT) + 5'(p_nxt) : 5'(V_SLOT);
         rd_addr_nxt = n_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         p        <= '0;
         n        <= '0;
         byte_cnt <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         rd_en    <= 1'b0;
         rd_slot  <= '0;
         rd_addr  <= '0;
         ct_valid <= 1'b0;
         ct_last  <= 1'b0;
      end else begin
         state    <= state_nxt;
         p        <= p_nxt;
         n        <= n_nxt;
         byte_cnt <= byte_nxt;
         busy     <= busy_nxt;
         done     <= done_nxt;
         rd_en    <= rd_en_nxt;
         rd_slot  <= rd_slot_nxt;
         rd_addr  <= rd_addr_nxt;
         ct_valid <= ct_valid_nxt;
         ct_last  <= ct_last_nxt;
      end
   end

endmodule
